// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: load funct3 encodings and the MEM/WB register layout.
package cpu_pkg;

  localparam int CPU_XLEN = 32;
  localparam int CPU_RAW  = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                memtoreg;
    logic [2:0]          funct3;
    logic [CPU_RAW-1:0]  rd_addr;
    logic [CPU_XLEN-1:0] alu_result;
    logic [CPU_XLEN-1:0] mem_rdata;
  } mem_wb_t;

endpackage

// File: rtl/load_ext.sv
// Load byte/halfword lane selection with sign/zero extension and alignment check.
module load_ext
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = offset[0];
      end
      F3_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_sel};
        misalign = offset[0];
      end
      // lw and reserved encodings take the whole word and need word alignment
      default: misalign = (offset != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: load extension, write-data select,
// register-file write port, misaligned-load flag and retired-instruction counter.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int RAW  = CPU_RAW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_regwrite,
  input  logic            in_memtoreg,
  input  logic [2:0]      in_funct3,
  input  logic [RAW-1:0]  in_rd_addr,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  output logic            wb_valid,
  output logic            wb_regwrite,
  output logic [RAW-1:0]  wb_rd_addr,
  output logic [XLEN-1:0] wb_wdata,
  output logic            load_misalign,
  output logic [31:0]     retired_count
);

  mem_wb_t         r;
  logic [31:0]     retired_q;
  logic [XLEN-1:0] ext_data;
  logic            ext_misalign;

  // flush outranks stall; only the control bits need clearing for a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= '0;
    end else if (flush) begin
      r.valid    <= 1'b0;
      r.regwrite <= 1'b0;
      r.memtoreg <= 1'b0;
    end else if (!stall) begin
      r.valid      <= in_valid;
      r.regwrite   <= in_regwrite;
      r.memtoreg   <= in_memtoreg;
      r.funct3     <= in_funct3;
      r.rd_addr    <= in_rd_addr;
      r.alu_result <= in_alu_result;
      r.mem_rdata  <= in_mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (r.valid && !stall) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata    (r.mem_rdata),
    .offset   (r.alu_result[1:0]),
    .funct3   (r.funct3),
    .data     (ext_data),
    .misalign (ext_misalign)
  );

  assign wb_valid      = r.valid;
  assign wb_rd_addr    = r.rd_addr;
  assign wb_wdata      = r.memtoreg ? ext_data : r.alu_result;
  assign load_misalign = r.valid & r.memtoreg & ext_misalign;
  assign wb_regwrite   = r.valid & r.regwrite & (r.rd_addr != '0) & ~load_misalign;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, stall/flush/wrap
// sequences, then randomized traffic against a behavioural model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        in_valid, in_regwrite, in_memtoreg;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_alu_result, in_mem_rdata;
  logic        wb_valid, wb_regwrite, load_misalign;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_wdata, retired_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .RAW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_funct3(in_funct3), .in_rd_addr(in_rd_addr),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr),
    .wb_wdata(wb_wdata), .load_misalign(load_misalign), .retired_count(retired_count)
  );

  typedef struct {
    logic        v, rw, mt;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, rdata;
    logic        e_rw;
    logic [31:0] e_wd;
    logic        e_mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic rw, input logic mt, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata);
    @(negedge clk);
    rst_n = r; stall = s; flush = f;
    in_valid = v; in_regwrite = rw; in_memtoreg = mt; in_funct3 = f3;
    in_rd_addr = rd; in_alu_result = alu; in_mem_rdata = rdata;
  endtask

  // Load result from the architectural rules: shift the word down to the addressed lane.
  task automatic ref_load(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                          output logic [31:0] wd, output logic mis);
    int          off;
    logic [31:0] b, h;
    off = int'(alu[1:0]);
    b   = (rdata >> (8 * off)) & 32'hFF;
    h   = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    begin wd = (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b; mis = 1'b0; end
      3'd4:    begin wd = b;                                         mis = 1'b0; end
      3'd1:    begin wd = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h; mis = (off % 2) != 0; end
      3'd5:    begin wd = h;                                         mis = (off % 2) != 0; end
      default: begin wd = rdata;                                     mis = off != 0; end
    endcase
  endtask

  vec_t tbl[$];

  // behavioural model state
  logic        m_v, m_rw, m_mt;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdata;
  logic [31:0] m_cnt;

  initial begin
    logic [31:0] exp_cnt;
    logic        prev_v;
    logic [31:0] ewd;
    logic        emis, e_mis, e_rw;
    logic        r, s, f;

    // ---------------- reset ----------------
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 5'd7, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    @(posedge clk);
    @(posedge clk); #1;
    check("rst wb_valid",      {31'd0, wb_valid}, 32'd0);
    check("rst wb_regwrite",   {31'd0, wb_regwrite}, 32'd0);
    check("rst wb_rd_addr",    {27'd0, wb_rd_addr}, 32'd0);
    check("rst wb_wdata",      wb_wdata, 32'd0);
    check("rst load_misalign", {31'd0, load_misalign}, 32'd0);
    check("rst retired_count", retired_count, 32'd0);

    // ---------------- directed vector table ----------------
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd2, 5'd5,  32'h0000_1234, 32'h0,         1'b1, 32'h0000_1234, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd0, 5'd6,  32'h0000_1003, 32'h80FF_7F01, 1'b1, 32'hFFFF_FF80, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd4, 5'd6,  32'h0000_1003, 32'h80FF_7F01, 1'b1, 32'h0000_0080, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd1, 5'd7,  32'h0000_1002, 32'h80FF_7F01, 1'b1, 32'hFFFF_80FF, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd5, 5'd8,  32'h0000_1000, 32'h80FF_7F01, 1'b1, 32'h0000_7F01, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd2, 5'd9,  32'h0000_1000, 32'h80FF_7F01, 1'b1, 32'h80FF_7F01, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd2, 5'd10, 32'h0000_1002, 32'h80FF_7F01, 1'b0, 32'h80FF_7F01, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd2, 5'd0,  32'h0000_0055, 32'h0,         1'b0, 32'h0000_0055, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd1, 5'd11, 32'h0000_1001, 32'h80FF_7F01, 1'b0, 32'h0000_7F01, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd0, 5'd12, 32'h0000_1001, 32'h80FF_7F01, 1'b1, 32'h0000_007F, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd3, 5'd13, 32'h0000_1000, 32'h1357_9BDF, 1'b1, 32'h1357_9BDF, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd6, 5'd14, 32'h0000_1001, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd2, 5'd15, 32'h0000_0077, 32'h0,         1'b0, 32'h0000_0077, 1'b0});

    exp_cnt = 32'd0;
    prev_v  = 1'b0;
    foreach (tbl[i]) begin
      drive(1'b1, 1'b0, 1'b0, tbl[i].v, tbl[i].rw, tbl[i].mt, tbl[i].f3, tbl[i].rd,
            tbl[i].alu, tbl[i].rdata);
      @(posedge clk); #1;
      if (prev_v) exp_cnt = exp_cnt + 32'd1;
      prev_v = tbl[i].v;
      check($sformatf("vec%0d wb_valid", i),      {31'd0, wb_valid}, {31'd0, tbl[i].v});
      check($sformatf("vec%0d wb_regwrite", i),   {31'd0, wb_regwrite}, {31'd0, tbl[i].e_rw});
      check($sformatf("vec%0d wb_rd_addr", i),    {27'd0, wb_rd_addr}, {27'd0, tbl[i].rd});
      check($sformatf("vec%0d wb_wdata", i),      wb_wdata, tbl[i].e_wd);
      check($sformatf("vec%0d load_misalign", i), {31'd0, load_misalign}, {31'd0, tbl[i].e_mis});
      check($sformatf("vec%0d retired_count", i), retired_count, exp_cnt);
    end

    // ---------------- stall hold ----------------
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 5'd9, 32'h0000_ABCD, 32'h0);
    @(posedge clk); #1;
    if (prev_v) exp_cnt = exp_cnt + 32'd1;
    check("pre-stall wb_wdata", wb_wdata, 32'h0000_ABCD);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 5'd3, 32'h0000_1111, 32'h0);
      @(posedge clk); #1;
      check($sformatf("stall%0d wb_valid", k),    {31'd0, wb_valid}, 32'd1);
      check($sformatf("stall%0d wb_rd_addr", k),  {27'd0, wb_rd_addr}, 32'd9);
      check($sformatf("stall%0d wb_wdata", k),    wb_wdata, 32'h0000_ABCD);
      check($sformatf("stall%0d wb_regwrite", k), {31'd0, wb_regwrite}, 32'd1);
      check($sformatf("stall%0d count", k),       retired_count, exp_cnt);
    end

    // ---------------- flush with stall ----------------
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 5'd3, 32'h0000_2222, 32'h0);
    @(posedge clk); #1;
    check("flush+stall wb_valid",    {31'd0, wb_valid}, 32'd0);
    check("flush+stall wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
    check("flush+stall count",       retired_count, exp_cnt);

    // ---------------- counter wrap ----------------
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 5'd4, 32'h0000_0042, 32'h0);
    @(posedge clk); #1;
    check("wrap load count", retired_count, exp_cnt);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    @(posedge clk); #1;
    check("wrap held count", retired_count, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("wrap count", retired_count, 32'd0);
    check("wrap wb_valid", {31'd0, wb_valid}, 32'd0);

    // ---------------- randomized traffic vs model ----------------
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    m_v = 0; m_rw = 0; m_mt = 0; m_f3 = 0; m_rd = 0; m_alu = 0; m_rdata = 0; m_cnt = 0;

    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 99) >= 3);
      s = ($urandom_range(0, 99) < 25);
      f = ($urandom_range(0, 99) < 10);
      drive(r, s, f, $urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, $urandom);
      @(posedge clk);
      if (!r) begin
        m_v = 0; m_rw = 0; m_mt = 0; m_f3 = 0; m_rd = 0; m_alu = 0; m_rdata = 0; m_cnt = 0;
      end else begin
        if (m_v && !s) m_cnt = m_cnt + 32'd1;
        if (f) begin
          m_v = 0; m_rw = 0; m_mt = 0;
        end else if (!s) begin
          m_v = in_valid; m_rw = in_regwrite; m_mt = in_memtoreg; m_f3 = in_funct3;
          m_rd = in_rd_addr; m_alu = in_alu_result; m_rdata = in_mem_rdata;
        end
      end
      #1;
      ref_load(m_f3, m_alu, m_rdata, ewd, emis);
      e_mis = m_v & m_mt & emis;
      e_rw  = m_v & m_rw & (m_rd != 5'd0) & ~e_mis;
      check($sformatf("rnd%0d wb_valid", n),      {31'd0, wb_valid}, {31'd0, m_v});
      check($sformatf("rnd%0d wb_regwrite", n),   {31'd0, wb_regwrite}, {31'd0, e_rw});
      check($sformatf("rnd%0d load_misalign", n), {31'd0, load_misalign}, {31'd0, e_mis});
      check($sformatf("rnd%0d retired_count", n), retired_count, m_cnt);
      if (m_v) begin
        check($sformatf("rnd%0d wb_rd_addr", n), {27'd0, wb_rd_addr}, {27'd0, m_rd});
        check($sformatf("rnd%0d wb_wdata", n),   wb_wdata, m_mt ? ewd : m_alu);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
